// File: rtl/uart_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_sequencer
// Purpose  : Assembles NBYTES UART bytes into a little-endian frame, publishes
//            it and optionally echoes it back byte by byte via the TX handshake.
//            Optional feature macro: FRAME_CHECKSUM_EN (last byte = XOR of rest).
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_sequencer #(
   parameter int NBYTES      = 8,
   parameter int TIMEOUT_CYC = 100000
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_byte,
   input  logic                  tx_ready,
   output logic                  tx_start,
   output logic [7:0]            tx_byte,
   input  logic                  echo_en,
   output logic                  frame_valid,
   output logic [8*NBYTES-1:0]   frame_data,
   output logic                  timeout_err,
   output logic                  overrun,
   output logic                  chk_err,
   output logic                  busy
);

   localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int TW = $clog2(TIMEOUT_CYC);
   localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_GUARD = 2'd2,
      S_DRAIN = 2'd3
   } tx_state_e;

   // RX side
   logic [CW-1:0]             rx_cnt_q, rx_cnt_d;
   logic [TW-1:0]             idle_cnt_q, idle_cnt_d;
   logic [NBYTES-1:0][7:0]    shadow_q, shadow_d;
   logic [NBYTES-1:0][7:0]    frame_data_q, frame_data_d;
   logic                      frame_valid_q, frame_valid_d;
   logic                      timeout_err_q, timeout_err_d;
   logic                      chk_err_q, chk_err_d;
   logic                      overrun_q, overrun_d;
   logic [NBYTES-1:0][7:0]    pend_data_q, pend_data_d;
   logic                      pending_q, pending_d;
   // TX side
   tx_state_e                 state_q, state_d;
   logic [CW-1:0]             idx_q, idx_d;
   logic [NBYTES-1:0][7:0]    tx_shadow_q, tx_shadow_d;
   logic                      tx_start_q, tx_start_d;
   logic [7:0]                tx_byte_q, tx_byte_d;

   logic [NBYTES-1:0][7:0]    frame_w;
   logic                      csum_ok_w;
`ifdef FRAME_CHECKSUM_EN
   logic [7:0]                csum_w;
`endif

   always_comb begin
      rx_cnt_d      = rx_cnt_q;
      idle_cnt_d    = idle_cnt_q;
      shadow_d      = shadow_q;
      frame_data_d  = frame_data_q;
      frame_valid_d = 1'b0;
      timeout_err_d = 1'b0;
      chk_err_d     = 1'b0;
      overrun_d     = overrun_q;
      pend_data_d   = pend_data_q;
      pending_d     = pending_q;
      state_d       = state_q;
      idx_d         = idx_q;
      tx_shadow_d   = tx_shadow_q;
      tx_start_d    = 1'b0;
      tx_byte_d     = tx_byte_q;

      frame_w           = shadow_q;
      frame_w[rx_cnt_q] = rx_byte;

`ifdef FRAME_CHECKSUM_EN
      csum_w = 8'h00;
      for (int i = 0; i < NBYTES - 1; i++) begin
         csum_w = csum_w ^ shadow_q[i];
      end
      csum_ok_w = (csum_w == rx_byte);
`else
      csum_ok_w = 1'b1;
`endif

      // TX sequencing is evaluated first so that a frame completing in the
      // same cycle the FSM drains the pending slot lands without an overrun.
      case (state_q)
         S_IDLE: begin
            if (pending_q) begin
               tx_shadow_d = pend_data_q;
               pending_d   = 1'b0;
               idx_d       = '0;
               state_d     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (tx_ready) begin
               tx_start_d = 1'b1;
               tx_byte_d  = tx_shadow_q[idx_q];
               state_d    = S_GUARD;
            end
         end
         S_GUARD: state_d = S_DRAIN;
         S_DRAIN: begin
            if (tx_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = S_IDLE;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = S_ISSUE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (rx_valid) begin
         shadow_d[rx_cnt_q] = rx_byte;
         idle_cnt_d         = '0;
         if (rx_cnt_q == LAST_IDX) begin
            rx_cnt_d = '0;
            if (csum_ok_w) begin
               frame_data_d  = frame_w;
               frame_valid_d = 1'b1;
               if (echo_en) begin
                  if (pending_d) begin
                     overrun_d = 1'b1;
                  end
                  pend_data_d = frame_w;
                  pending_d   = 1'b1;
               end
            end else begin
               chk_err_d = 1'b1;
            end
         end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
         end
      end else if (rx_cnt_q != '0) begin
         if (idle_cnt_q == TO_LAST) begin
            rx_cnt_d      = '0;
            idle_cnt_d    = '0;
            timeout_err_d = 1'b1;
         end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
         end
      end else begin
         idle_cnt_d = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         rx_cnt_q      <= '0;
         idle_cnt_q    <= '0;
         shadow_q      <= '0;
         frame_data_q  <= '0;
         frame_valid_q <= 1'b0;
         timeout_err_q <= 1'b0;
         chk_err_q     <= 1'b0;
         overrun_q     <= 1'b0;
         pend_data_q   <= '0;
         pending_q     <= 1'b0;
         state_q       <= S_IDLE;
         idx_q         <= '0;
         tx_shadow_q   <= '0;
         tx_start_q    <= 1'b0;
         tx_byte_q     <= 8'h00;
      end else begin
         rx_cnt_q      <= rx_cnt_d;
         idle_cnt_q    <= idle_cnt_d;
         shadow_q      <= shadow_d;
         frame_data_q  <= frame_data_d;
         frame_valid_q <= frame_valid_d;
         timeout_err_q <= timeout_err_d;
         chk_err_q     <= chk_err_d;
         overrun_q     <= overrun_d;
         pend_data_q   <= pend_data_d;
         pending_q     <= pending_d;
         state_q       <= state_d;
         idx_q         <= idx_d;
         tx_shadow_q   <= tx_shadow_d;
         tx_start_q    <= tx_start_d;
         tx_byte_q     <= tx_byte_d;
      end
   end

   assign tx_start    = tx_start_q;
   assign tx_byte     = tx_byte_q;
   assign frame_valid = frame_valid_q;
   assign frame_data  = frame_data_q;
   assign timeout_err = timeout_err_q;
   assign overrun     = overrun_q;
   assign chk_err     = chk_err_q;
   assign busy        = (state_q != S_IDLE) || pending_q;

endmodule
`default_nettype wire
